uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_bit_timer.sv | 56 +++++
 rtl/uart_tx.sv | 151 +++++++++++++++
 tb/tb_uart_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by both the transmitter and the receiver.
//   DATA_WIDTH      : data bits per frame
//   PRESCALE_WIDTH  : width of the Prescale (clk cycles per bit) input
//   BIT_CNT_W       : width of a counter indexing the data bits
//   tx_state_e      : transmitter FSM encoding
//   PAR_EVEN/PAR_ODD: PAR_TYP encodings
// ---------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_WIDTH     = 8;
   localparam int PRESCALE_WIDTH = 6;
   localparam int BIT_CNT_W      = $clog2(DATA_WIDTH);

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } tx_state_e;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// ---------------------------------------------------------------------------
// uart_tx_bit_timer
// Bit-period timing for the UART transmitter. An edge counter runs
// 0..prescale_i-1 and wraps; each wrap raises bit_done_o for one cycle and
// advances the bit counter.
//   clk_i        : oversampling clock
//   rst_ni       : asynchronous active-low reset
//   en_i         : counting enable; when low both counters are held at 0
//   clr_i        : on a wrap, restart the bit counter at 0 instead of +1
//   prescale_i   : clk cycles per bit (latched copy from the FSM)
//   bit_done_o   : last cycle of the current bit period
//   bit_cnt_o    : number of completed bits since the last clear
// ---------------------------------------------------------------------------
module uart_tx_bit_timer
   import uart_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      en_i,
   input  logic                      clr_i,
   input  logic [PRESCALE_WIDTH-1:0] prescale_i,
   output logic                      bit_done_o,
   output logic [BIT_CNT_W-1:0]      bit_cnt_o
);

   logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
   logic [BIT_CNT_W-1:0]      bit_q,  bit_d;

   assign bit_done_o = en_i && (edge_q == (prescale_i - PRESCALE_WIDTH'(1)));
   assign bit_cnt_o  = bit_q;

   always_comb begin
      edge_d = edge_q;
      bit_d  = bit_q;
      if (!en_i) begin
         edge_d = '0;
         bit_d  = '0;
      end else if (bit_done_o) begin
         edge_d = '0;
         bit_d  = clr_i ? '0 : bit_q + BIT_CNT_W'(1);
      end else begin
         edge_d = edge_q + PRESCALE_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else begin
         edge_q <= edge_d;
         bit_q  <= bit_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, one stop bit. Each bit lasts Prescale clk cycles.
//   clk        : oversampling clock (rising edge)
//   rst        : asynchronous active-low reset
//   P_DATA     : parallel word to send
//   Data_Valid : request strobe, accepted only while idle
//   PAR_EN     : 1 inserts a parity bit after the data
//   PAR_TYP    : 0 even parity, 1 odd parity
//   Prescale   : clk cycles per bit (4..63)
//   TX_OUT     : registered serial line, idle high
//   busy       : registered, high while a frame is in flight
// ---------------------------------------------------------------------------
module uart_tx
   import uart_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [DATA_WIDTH-1:0]     P_DATA,
   input  logic                      Data_Valid,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   output logic                      TX_OUT,
   output logic                      busy
);

   tx_state_e                 state_q, state_d;
   logic [DATA_WIDTH-1:0]     data_q;
   logic                      par_en_q, par_typ_q;
   logic [PRESCALE_WIDTH-1:0] prescale_q;
   logic                      tx_q, tx_d;
   logic                      busy_q, busy_d;
   logic                      armed_q;
   logic                      accept;
   logic                      timer_clr;
   logic                      bit_done;
   logic [BIT_CNT_W-1:0]      bit_cnt;
   logic [BIT_CNT_W-1:0]      nxt_idx;
   logic                      par_bit;

   // Bit counter is cleared on leaving START, so inside DATA it indexes the
   // data bit currently on the line.
   uart_tx_bit_timer u_timer (
      .clk_i      (clk),
      .rst_ni     (rst),
      .en_i       (state_q != ST_IDLE),
      .clr_i      (timer_clr),
      .prescale_i (prescale_q),
      .bit_done_o (bit_done),
      .bit_cnt_o  (bit_cnt)
   );

   assign nxt_idx = bit_cnt + BIT_CNT_W'(1);
   assign par_bit = (par_typ_q == PAR_ODD) ? ~(^data_q) : (^data_q);

   // Outputs are registered, so the mux looks at the bit that will be on the
   // line after this edge rather than the current one.
   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      accept    = 1'b0;
      timer_clr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            // armed_q blocks a request in the cycle reset is released.
            if (Data_Valid && armed_q) begin
               accept  = 1'b1;
               state_d = ST_START;
               tx_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ST_START: begin
            if (bit_done) begin
               state_d   = ST_DATA;
               tx_d      = data_q[0];
               timer_clr = 1'b1;
            end
         end
         ST_DATA: begin
            if (bit_done) begin
               if (bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                  timer_clr = 1'b1;
                  if (par_en_q) begin
                     state_d = ST_PARITY;
                     tx_d    = par_bit;
                  end else begin
                     state_d = ST_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  tx_d = data_q[nxt_idx];
               end
            end
         end
         ST_PARITY: begin
            if (bit_done) begin
               state_d   = ST_STOP;
               tx_d      = 1'b1;
               timer_clr = 1'b1;
            end
         end
         ST_STOP: begin
            if (bit_done) begin
               state_d   = ST_IDLE;
               tx_d      = 1'b1;
               busy_d    = 1'b0;
               timer_clr = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         armed_q    <= 1'b0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= PAR_EVEN;
         prescale_q <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         armed_q <= 1'b1;
         if (accept) begin
            data_q     <= P_DATA;
            par_en_q   <= PAR_EN;
            par_typ_q  <= PAR_TYP;
            prescale_q <= Prescale;
         end
      end
   end

   assign TX_OUT = tx_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] P_DATA = 8'h00;
   logic       Data_Valid = 1'b0;
   logic       PAR_EN = 1'b0;
   logic       PAR_TYP = 1'b0;
   logic [5:0] Prescale = 6'd8;
   logic       TX_OUT;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   uart_tx dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .Prescale   (Prescale),
      .TX_OUT     (TX_OUT),
      .busy       (busy)
   );

   // Reference line value for cycle c (1 = first cycle after the accept edge).
   function automatic logic exp_tx(input logic [7:0] d, input logic pe, input logic pt,
                                   input int p, input int c);
      int b;
      b = (c - 1) / p;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
      if (pe && b == 9) return (^d) ^ pt;
      return 1'b1;
   endfunction

   // Present a request on a falling edge; it is accepted on the next rising edge.
   task automatic send(input logic [7:0] d, input logic pe, input logic pt,
                       input logic [5:0] p, input bit hold);
      @(negedge clk);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Prescale   = p;
      Data_Valid = 1'b1;
      @(posedge clk);
      #1;
      if (!hold) Data_Valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         Data_Valid = (i % 2 == 0);
         @(negedge clk);
         n_tests++;
         if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold cyc %0d: TX_OUT=%b busy=%b, want TX_OUT=1 busy=0", i, TX_OUT, busy);
         end
      end
      // Request present while reset releases must be ignored.
      rst = 1'b1;
      Data_Valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release_dv: TX_OUT=%b busy=%b, want TX_OUT=1 busy=0", TX_OUT, busy);
      end
      Data_Valid = 1'b0;
      @(negedge clk);
      n_tests++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_after: TX_OUT=%b busy=%b, want TX_OUT=1 busy=0", TX_OUT, busy);
      end
   endtask

   task automatic test_no_parity();
      logic et, eb;
      send(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0);
      for (int c = 1; c <= 81; c++) begin
         @(negedge clk);
         et = (c <= 80) ? exp_tx(8'hA5, 1'b0, 1'b0, 8, c) : 1'b1;
         eb = (c <= 80);
         n_tests++;
         if (TX_OUT !== et || busy !== eb) begin
            n_fail++;
            $display("FAIL no_parity cyc %0d: TX_OUT=%b busy=%b, want TX_OUT=%b busy=%b", c, TX_OUT, busy, et, eb);
         end
      end
   endtask

   task automatic test_parity();
      logic et, eb;
      for (int t = 0; t < 2; t++) begin
         send(8'h07, 1'b1, t[0], 6'd16, 1'b0);
         for (int c = 1; c <= 177; c++) begin
            @(negedge clk);
            et = (c <= 176) ? exp_tx(8'h07, 1'b1, t[0], 16, c) : 1'b1;
            eb = (c <= 176);
            n_tests++;
            if (TX_OUT !== et || busy !== eb) begin
               n_fail++;
               $display("FAIL parity typ=%0d cyc %0d: TX_OUT=%b busy=%b, want TX_OUT=%b busy=%b", t, c, TX_OUT, busy, et, eb);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic et, eb;
      send(8'h3C, 1'b0, 1'b0, 6'd8, 1'b1);
      for (int c = 1; c <= 162; c++) begin
         @(negedge clk);
         if (c <= 80) begin
            et = exp_tx(8'h3C, 1'b0, 1'b0, 8, c); eb = 1'b1;
         end else if (c == 81) begin
            et = 1'b1; eb = 1'b0;
         end else if (c <= 161) begin
            et = exp_tx(8'hFF, 1'b0, 1'b0, 8, c - 81); eb = 1'b1;
         end else begin
            et = 1'b1; eb = 1'b0;
         end
         n_tests++;
         if (TX_OUT !== et || busy !== eb) begin
            n_fail++;
            $display("FAIL back_to_back cyc %0d: TX_OUT=%b busy=%b, want TX_OUT=%b busy=%b", c, TX_OUT, busy, et, eb);
         end
         if (c == 20)  P_DATA = 8'hFF;
         if (c == 100) Data_Valid = 1'b0;
      end
   endtask

   task automatic test_config_freeze();
      logic et, eb;
      send(8'h5A, 1'b0, 1'b0, 6'd8, 1'b0);
      for (int c = 1; c <= 81; c++) begin
         @(negedge clk);
         et = (c <= 80) ? exp_tx(8'h5A, 1'b0, 1'b0, 8, c) : 1'b1;
         eb = (c <= 80);
         n_tests++;
         if (TX_OUT !== et || busy !== eb) begin
            n_fail++;
            $display("FAIL config_freeze cyc %0d: TX_OUT=%b busy=%b, want TX_OUT=%b busy=%b", c, TX_OUT, busy, et, eb);
         end
         if (c == 30) begin
            Prescale = 6'd16;
            PAR_EN   = 1'b1;
            PAR_TYP  = 1'b1;
            P_DATA   = 8'h00;
         end
      end
   endtask

   task automatic test_mid_reset();
      logic et, eb;
      send(8'hF0, 1'b0, 1'b0, 6'd8, 1'b0);
      for (int c = 1; c <= 35; c++) begin
         @(negedge clk);
         et = exp_tx(8'hF0, 1'b0, 1'b0, 8, c);
         n_tests++;
         if (TX_OUT !== et || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_pre cyc %0d: TX_OUT=%b busy=%b, want TX_OUT=%b busy=1", c, TX_OUT, busy, et);
         end
      end
      // Cycle 35 is inside data bit 3 (a 0 for 0xF0); reset must act without a clock edge.
      #1 rst = 1'b0;
      #1;
      n_tests++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_async: TX_OUT=%b busy=%b, want TX_OUT=1 busy=0", TX_OUT, busy);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if (TX_OUT !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_release: TX_OUT=%b busy=%b, want TX_OUT=1 busy=0", TX_OUT, busy);
      end
      send(8'h81, 1'b0, 1'b0, 6'd8, 1'b0);
      for (int c = 1; c <= 81; c++) begin
         @(negedge clk);
         et = (c <= 80) ? exp_tx(8'h81, 1'b0, 1'b0, 8, c) : 1'b1;
         eb = (c <= 80);
         n_tests++;
         if (TX_OUT !== et || busy !== eb) begin
            n_fail++;
            $display("FAIL mid_reset_frame cyc %0d: TX_OUT=%b busy=%b, want TX_OUT=%b busy=%b", c, TX_OUT, busy, et, eb);
         end
      end
   endtask

   initial begin
      test_reset();
      test_no_parity();
      test_parity();
      test_back_to_back();
      test_config_freeze();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
